cache_fill_fsm: RTL and testbench

Parametrised miss handler for the next-generation memory system, replacing the single-cycle data/instruction memory path with cache + multi-cycle main memory. On a cache miss it issues pipelined word reads to main memory and streams returned words into the cache data array. After the last word it writes the tag array. An optional critical-word-first mode wraps the fetch order starting at the missed word.

---
 rtl/cache_pkg.sv | 30 +++
 rtl/cache_fill_fsm_seq.sv | 21 ++
 rtl/cache_fill_fsm.sv | 113 +++++++++++
 tb/tb_cache_fill_fsm.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache miss handler: FSM state encoding,
// a constant log2 helper and the address-offset constants of the default block geometry.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fillState_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    // Byte-offset bits below the block boundary for a given geometry.
    function automatic int offBits(input int wordsPerBlock, input int dataW);
        return clog2(wordsPerBlock) + clog2(dataW / 8);
    endfunction

    localparam int DATA_W_DEF = 16;
    localparam int WPB_DEF    = 8;
    localparam int WORD_BYTES = DATA_W_DEF / 8;
    localparam int OFF        = offBits(WPB_DEF, DATA_W_DEF);

endpackage

// File: rtl/cache_fill_fsm_seq.sv
// Word-order generator: maps a request/receive count to a word index within
// the block, either linear or wrapped around the missed word.
module fill_word_seq
    import cache_pkg::*;
#(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int CWF = 0,
    localparam int IDX_W = clog2(WORDS_PER_BLOCK)
) (
    input  logic [IDX_W-1:0] count,
    input  logic [IDX_W-1:0] missWord,
    output logic [IDX_W-1:0] wordIndex
);

    // Block size is a power of two, so the add wraps modulo WORDS_PER_BLOCK.
    always_comb begin
        wordIndex = count;
        if (CWF != 0) wordIndex = missWord + count;
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: issues pipelined word reads for the missing block,
// streams returned words into the data array, then writes the tag.
//   state | meaning
//   IDLE  | waiting for a miss; base and missed word latched on entry to FILL
//   FILL  | requests issued back-to-back, responses written as they return
//   DONE  | single cycle tag/valid write, then back to IDLE
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int CWF = 0,
    localparam int IDX_W = clog2(WORDS_PER_BLOCK)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    output logic              fsm_busy,
    output logic              memory_req,
    output logic [ADDR_W-1:0] memory_address,
    input  logic              memory_data_valid,
    input  logic [DATA_W-1:0] memory_data,
    output logic              write_data_array,
    output logic [IDX_W-1:0]  fill_word_index,
    output logic [DATA_W-1:0] fill_data,
    output logic              critical_word_valid,
    output logic              write_tag_array
);

    localparam int BYTE_W = clog2(DATA_W / 8);
    localparam int CNT_W  = IDX_W + 1;
    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << offBits(WORDS_PER_BLOCK, DATA_W)) - 1);

    fillState_t        state, stateNext;
    logic [ADDR_W-1:0] baseAddr, baseAddrNext;
    logic [IDX_W-1:0]  missWord, missWordNext;
    logic [CNT_W-1:0]  issueCnt, issueCntNext;
    logic [CNT_W-1:0]  recvCnt, recvCntNext;
    logic [IDX_W-1:0]  issueIdx, recvIdx;
    logic              acceptWord;

    fill_word_seq #(.WORDS_PER_BLOCK(WORDS_PER_BLOCK), .CWF(CWF)) issueSeq (
        .count    (issueCnt[IDX_W-1:0]),
        .missWord (missWord),
        .wordIndex(issueIdx)
    );

    fill_word_seq #(.WORDS_PER_BLOCK(WORDS_PER_BLOCK), .CWF(CWF)) recvSeq (
        .count    (recvCnt[IDX_W-1:0]),
        .missWord (missWord),
        .wordIndex(recvIdx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baseAddr <= '0;
            missWord <= '0;
            issueCnt <= '0;
            recvCnt  <= '0;
        end else begin
            state    <= stateNext;
            baseAddr <= baseAddrNext;
            missWord <= missWordNext;
            issueCnt <= issueCntNext;
            recvCnt  <= recvCntNext;
        end
    end

    // Responses beyond the block's word count are dropped even while in FILL.
    assign acceptWord = (state == FILL) && memory_data_valid && (recvCnt < LAST);

    always_comb begin
        stateNext    = state;
        baseAddrNext = baseAddr;
        missWordNext = missWord;
        issueCntNext = issueCnt;
        recvCntNext  = recvCnt;
        case (state)
            IDLE: begin
                if (miss_detected) begin
                    stateNext    = FILL;
                    baseAddrNext = miss_address & ~OFF_MASK;
                    missWordNext = IDX_W'(miss_address >> BYTE_W);
                    issueCntNext = '0;
                    recvCntNext  = '0;
                end
            end
            FILL: begin
                if (issueCnt < LAST) issueCntNext = issueCnt + 1'b1;
                if (acceptWord) begin
                    recvCntNext = recvCnt + 1'b1;
                    if (recvCnt == LAST - 1'b1) stateNext = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign fsm_busy            = (state != IDLE);
    assign memory_req          = (state == FILL) && (issueCnt < LAST);
    assign memory_address      = baseAddr | (ADDR_W'(issueIdx) << BYTE_W);
    assign write_data_array    = acceptWord;
    assign fill_word_index     = recvIdx;
    assign fill_data           = memory_data;
    assign critical_word_valid = acceptWord && (recvIdx == missWord);
    assign write_tag_array     = (state == DONE);

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: three configurations (linear, wrapped,
// 4x32-bit block) driven by a fixed-latency memory model.
module tb_cache_fill_fsm;

    localparam int LAT = 4;

    typedef struct {
        logic [2:0]  idx;
        logic        crit;
        logic [31:0] data;
    } wrExp_t;

    typedef struct {
        int          due;
        logic [15:0] addr;
    } memTxn_t;

    typedef logic [15:0] addrVec_t [8];
    typedef logic [2:0]  idxVec_t [8];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    logic        miss [3]        = '{1'b0, 1'b0, 1'b0};
    logic [15:0] missAddr [3]    = '{16'h0, 16'h0, 16'h0};
    logic        modelValid [3]  = '{1'b0, 1'b0, 1'b0};
    logic [31:0] modelData [3]   = '{32'h0, 32'h0, 32'h0};
    logic        forceValid [3]  = '{1'b0, 1'b0, 1'b0};
    logic [31:0] forceData [3]   = '{32'h0, 32'h0, 32'h0};
    logic        dutValid [3];
    logic [31:0] dutData [3];

    logic        busy [3], req [3], wda [3], crit [3], tag [3];
    logic [15:0] addr [3];
    logic [2:0]  idx [3];
    logic [31:0] fdata [3];

    logic        busy0, req0, wda0, crit0, tag0, busy1, req1, wda1, crit1, tag1, busy2, req2, wda2, crit2, tag2;
    logic [15:0] addr0, addr1, addr2, fd0, fd1, dutData0, dutData1;
    logic [2:0]  idx0, idx1;
    logic [1:0]  idx2;
    logic [31:0] fd2;

    logic [15:0] reqQ [3][$];
    wrExp_t      wrQ [3][$];
    int          tagQ [3][$];
    memTxn_t     memQ [3][$];
    int          wrCnt [3]   = '{0, 0, 0};
    int          tagCnt [3]  = '{0, 0, 0};
    logic        prevTag [3] = '{1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    always_comb begin
        for (int g = 0; g < 3; g++) begin
            dutValid[g] = modelValid[g] | forceValid[g];
            dutData[g]  = forceValid[g] ? forceData[g] : modelData[g];
        end
    end
    assign dutData0 = dutData[0][15:0];
    assign dutData1 = dutData[1][15:0];

    assign busy[0] = busy0;  assign req[0] = req0;  assign wda[0] = wda0;  assign crit[0] = crit0;  assign tag[0] = tag0;
    assign busy[1] = busy1;  assign req[1] = req1;  assign wda[1] = wda1;  assign crit[1] = crit1;  assign tag[1] = tag1;
    assign busy[2] = busy2;  assign req[2] = req2;  assign wda[2] = wda2;  assign crit[2] = crit2;  assign tag[2] = tag2;
    assign addr[0] = addr0;  assign addr[1] = addr1;  assign addr[2] = addr2;
    assign idx[0] = idx0;    assign idx[1] = idx1;    assign idx[2] = {1'b0, idx2};
    assign fdata[0] = {16'h0, fd0};  assign fdata[1] = {16'h0, fd1};  assign fdata[2] = fd2;

    cache_fill_fsm #(.CWF(0)) dut0 (
        .clk(clk), .rst(rst), .miss_detected(miss[0]), .miss_address(missAddr[0]),
        .fsm_busy(busy0), .memory_req(req0), .memory_address(addr0),
        .memory_data_valid(dutValid[0]), .memory_data(dutData0),
        .write_data_array(wda0), .fill_word_index(idx0), .fill_data(fd0),
        .critical_word_valid(crit0), .write_tag_array(tag0)
    );

    cache_fill_fsm #(.CWF(1)) dut1 (
        .clk(clk), .rst(rst), .miss_detected(miss[1]), .miss_address(missAddr[1]),
        .fsm_busy(busy1), .memory_req(req1), .memory_address(addr1),
        .memory_data_valid(dutValid[1]), .memory_data(dutData1),
        .write_data_array(wda1), .fill_word_index(idx1), .fill_data(fd1),
        .critical_word_valid(crit1), .write_tag_array(tag1)
    );

    cache_fill_fsm #(.DATA_W(32), .WORDS_PER_BLOCK(4), .CWF(0)) dut2 (
        .clk(clk), .rst(rst), .miss_detected(miss[2]), .miss_address(missAddr[2]),
        .fsm_busy(busy2), .memory_req(req2), .memory_address(addr2),
        .memory_data_valid(dutValid[2]), .memory_data(dutData[2]),
        .write_data_array(wda2), .fill_word_index(idx2), .fill_data(fd2),
        .critical_word_valid(crit2), .write_tag_array(tag2)
    );

    function automatic logic [31:0] dataOf(input logic [15:0] a);
        return {~a, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic noteFail(input string name, input logic [31:0] act);
        checks++;
        $display("FAIL %s: got %0h with nothing expected", name, act);
    endtask

    // Memory model: a request seen in cycle c returns its word in cycle c+LAT.
    always @(posedge clk) begin
        for (int g = 0; g < 3; g++)
            if (req[g]) memQ[g].push_back('{due: cyc + LAT, addr: addr[g]});
        cyc = cyc + 1;
        #1;
        for (int g = 0; g < 3; g++) begin
            if (memQ[g].size() > 0 && memQ[g][0].due == cyc) begin
                modelValid[g] = 1'b1;
                modelData[g]  = dataOf(memQ[g][0].addr);
                void'(memQ[g].pop_front());
            end else begin
                modelValid[g] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        wrExp_t      e;
        logic [15:0] a;
        logic [31:0] mask;
        int          t;
        for (int g = 0; g < 3; g++) begin
            if (rst) begin
                prevTag[g] = 1'b0;
            end else begin
                mask = (g == 2) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
                if (req[g]) begin
                    check($sformatf("d%0d_busy_on_req", g), 32'(busy[g]), 32'd1);
                    if (reqQ[g].size() == 0) noteFail($sformatf("d%0d_req_unexpected", g), 32'(addr[g]));
                    else begin
                        a = reqQ[g].pop_front();
                        check($sformatf("d%0d_req_addr", g), 32'(addr[g]), 32'(a));
                    end
                end
                if (wda[g]) begin
                    wrCnt[g]++;
                    if (wrQ[g].size() == 0) noteFail($sformatf("d%0d_write_unexpected", g), 32'(idx[g]));
                    else begin
                        e = wrQ[g].pop_front();
                        check($sformatf("d%0d_write_idx", g), 32'(idx[g]), 32'(e.idx));
                        check($sformatf("d%0d_crit", g), 32'(crit[g]), 32'(e.crit));
                        check($sformatf("d%0d_fill_data", g), fdata[g], e.data & mask);
                    end
                end else if (crit[g]) begin
                    noteFail($sformatf("d%0d_crit_without_write", g), 32'(crit[g]));
                end
                if (tag[g]) begin
                    tagCnt[g]++;
                    if (tagQ[g].size() == 0) noteFail($sformatf("d%0d_tag_unexpected", g), 32'(cyc));
                    else begin
                        t = tagQ[g].pop_front();
                        check($sformatf("d%0d_tag_cycle", g), 32'(cyc), 32'(t));
                    end
                end
                if (prevTag[g]) check($sformatf("d%0d_busy_after_done", g), 32'(busy[g]), 32'd0);
                prevTag[g] = tag[g];
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expectFill(input int g, input int n, input addrVec_t av, input idxVec_t iv,
                              input logic [2:0] critIdx, input int tagCyc);
        for (int k = 0; k < n; k++) begin
            reqQ[g].push_back(av[k]);
            wrQ[g].push_back('{idx: iv[k], crit: (iv[k] == critIdx), data: dataOf(av[k])});
        end
        tagQ[g].push_back(tagCyc);
    endtask

    task automatic waitIdle(input int g, input int budget);
        int n;
        n = 0;
        while ((reqQ[g].size() + wrQ[g].size() + tagQ[g].size() != 0 || busy[g]) && n < budget) begin
            step(1);
            n++;
        end
        check($sformatf("d%0d_drained", g), 32'(reqQ[g].size() + wrQ[g].size() + tagQ[g].size()), 32'd0);
        step(2);
    endtask

    task automatic checkQuiet(input int g, input string tagName);
        check({tagName, "_busy"}, 32'(busy[g]), 32'd0);
        check({tagName, "_req"},  32'(req[g]),  32'd0);
        check({tagName, "_addr"}, 32'(addr[g]), 32'd0);
        check({tagName, "_wda"},  32'(wda[g]),  32'd0);
        check({tagName, "_idx"},  32'(idx[g]),  32'd0);
        check({tagName, "_crit"}, 32'(crit[g]), 32'd0);
        check({tagName, "_tag"},  32'(tag[g]),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t expected completion", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int tc, n, savedWr, savedTag;

        #12;
        for (int g = 0; g < 3; g++) checkQuiet(g, $sformatf("d%0d_reset", g));
        step(1);
        rst = 1'b0;
        step(2);

        // Linear fill, miss at 0x1236 (word 3); tag 12 cycles after the FILL entry cycle.
        tc = cyc + 1;
        expectFill(0, 8, '{16'h1230, 16'h1232, 16'h1234, 16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E},
                   '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}, 3'd3, tc + 12);
        miss[0] = 1'b1;  missAddr[0] = 16'h1236;
        step(1);
        miss[0] = 1'b0;
        waitIdle(0, 40);

        // Critical-word-first, miss at 0x123A (word 5).
        tc = cyc + 1;
        expectFill(1, 8, '{16'h123A, 16'h123C, 16'h123E, 16'h1230, 16'h1232, 16'h1234, 16'h1236, 16'h1238},
                   '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4}, 3'd5, tc + 12);
        miss[1] = 1'b1;  missAddr[1] = 16'h123A;
        step(1);
        miss[1] = 1'b0;
        waitIdle(1, 40);

        // 4 words of 32 bits, miss at 0x0107 (word 1).
        tc = cyc + 1;
        expectFill(2, 4, '{16'h0100, 16'h0104, 16'h0108, 16'h010C, 16'h0, 16'h0, 16'h0, 16'h0},
                   '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0}, 3'd1, tc + 8);
        miss[2] = 1'b1;  missAddr[2] = 16'h0107;
        step(1);
        miss[2] = 1'b0;
        waitIdle(2, 40);

        // Miss held through a fill: second fill samples in the IDLE cycle after DONE.
        tc = cyc + 1;
        expectFill(0, 8, '{16'h1230, 16'h1232, 16'h1234, 16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E},
                   '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}, 3'd3, tc + 12);
        expectFill(0, 8, '{16'h2040, 16'h2042, 16'h2044, 16'h2046, 16'h2048, 16'h204A, 16'h204C, 16'h204E},
                   '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}, 3'd6, tc + 26);
        savedTag = tagCnt[0];
        miss[0] = 1'b1;  missAddr[0] = 16'h1236;
        step(1);
        missAddr[0] = 16'h204C;
        n = 0;
        while (tagCnt[0] == savedTag && n < 40) begin
            step(1);
            n++;
        end
        check("held_first_tag_seen", 32'(tagCnt[0] - savedTag), 32'd1);
        step(3);
        miss[0] = 1'b0;
        waitIdle(0, 60);
        check("held_two_tags_only", 32'(tagCnt[0] - savedTag), 32'd2);

        // Reset after three returned words aborts the fill.
        savedWr = wrCnt[0];
        tc = cyc + 1;
        expectFill(0, 8, '{16'h1230, 16'h1232, 16'h1234, 16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E},
                   '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}, 3'd3, tc + 12);
        miss[0] = 1'b1;  missAddr[0] = 16'h1236;
        step(1);
        miss[0] = 1'b0;
        n = 0;
        while (wrCnt[0] - savedWr < 3 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("abort_three_written", 32'(wrCnt[0] - savedWr), 32'd3);
        #1;
        reqQ[0].delete();
        wrQ[0].delete();
        tagQ[0].delete();
        rst = 1'b1;
        #1;
        checkQuiet(0, "abort_async");
        savedWr  = wrCnt[0];
        savedTag = tagCnt[0];
        step(1);
        rst = 1'b0;
        step(10);
        check("abort_no_late_writes", 32'(wrCnt[0] - savedWr), 32'd0);
        check("abort_no_tag", 32'(tagCnt[0] - savedTag), 32'd0);

        // A stray valid while IDLE never writes.
        savedWr = wrCnt[0];
        forceValid[0] = 1'b1;  forceData[0] = 32'h0000_BEEF;
        #1;
        check("idle_valid_wda", 32'(wda[0]), 32'd0);
        check("idle_valid_crit", 32'(crit[0]), 32'd0);
        step(1);
        forceValid[0] = 1'b0;
        step(2);
        check("idle_valid_no_write", 32'(wrCnt[0] - savedWr), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
